// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: synchronises the external interrupt pin and sequences
// pipeline entry (drain, push return PC and flags, vector jump, service until RTI).
`default_nettype none

module interrupt_sequencer #(
  parameter int              PC_W         = 32,
  parameter int              FLAG_W       = 3,
  parameter int              DATA_W       = 16,
  parameter int              DRAIN_CYCLES = 4,
  parameter logic [PC_W-1:0] INT_VECTOR   = 'h0002
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              interrupt,
  input  logic [PC_W-1:0]   pc_next,
  input  logic [FLAG_W-1:0] flags,
  input  logic              stall_in,
  input  logic              rti_done,
  input  logic              push_ready,
  output logic              freeze_fetch,
  output logic              push_valid,
  output logic [DATA_W-1:0] push_data,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_vector,
  output logic              int_active
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAIN   = 3'd1,
    S_PUSH_HI = 3'd2,
    S_PUSH_LO = 3'd3,
    S_PUSH_F  = 3'd4,
    S_JUMP    = 3'd5,
    S_SERVICE = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_prev;
  logic [1:0]        r_arm;
  logic              r_pending;
  logic [CNT_W-1:0]  r_cnt;
  logic [PC_W-1:0]   r_ret_pc;
  logic [FLAG_W-1:0] r_ret_flags;
  logic              w_edge;
  logic              w_enter;
  logic              w_cnt_last;

  // r_arm marks when r_sync2 holds a real pin sample; until then r_prev reads
  // as high so a pin already asserted through reset is not taken as an edge.
  assign w_edge     = r_arm[1] & r_sync2 & ~r_prev;
  assign w_enter    = (r_state == S_IDLE) & r_pending;
  assign w_cnt_last = (r_cnt == CNT_W'(DRAIN_CYCLES - 1));
  assign pc_vector  = INT_VECTOR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    freeze_fetch = 1'b0;
    push_valid   = 1'b0;
    push_data    = '0;
    pc_load      = 1'b0;
    int_active   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        freeze_fetch = 1'b1;
        if (!stall_in && w_cnt_last) w_next = S_PUSH_HI;
      end
      S_PUSH_HI: begin
        freeze_fetch = 1'b1;
        push_valid   = 1'b1;
        push_data    = r_ret_pc[2*DATA_W-1:DATA_W];
        if (push_ready) w_next = S_PUSH_LO;
      end
      S_PUSH_LO: begin
        freeze_fetch = 1'b1;
        push_valid   = 1'b1;
        push_data    = r_ret_pc[DATA_W-1:0];
        if (push_ready) w_next = S_PUSH_F;
      end
      S_PUSH_F: begin
        freeze_fetch = 1'b1;
        push_valid   = 1'b1;
        push_data    = {{(DATA_W-FLAG_W){1'b0}}, r_ret_flags};
        if (push_ready) w_next = S_JUMP;
      end
      S_JUMP: begin
        pc_load = 1'b1;
        w_next  = S_SERVICE;
      end
      S_SERVICE: begin
        int_active = 1'b1;
        if (rti_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_prev      <= 1'b1;
      r_arm       <= 2'b00;
      r_pending   <= 1'b0;
      r_cnt       <= '0;
      r_ret_pc    <= '0;
      r_ret_flags <= '0;
    end else begin
      r_sync1 <= interrupt;
      r_sync2 <= r_sync1;
      r_arm   <= {r_arm[0], 1'b1};
      if (r_arm[1]) r_prev <= r_sync2;

      // Entry consumes the pending request; an edge in the same cycle is merged.
      if (w_enter) begin
        r_pending <= 1'b0;
      end else if (w_edge) begin
        r_pending <= 1'b1;
      end

      if (w_enter) begin
        r_ret_pc    <= pc_next;
        r_ret_flags <= flags;
        r_cnt       <= '0;
      end else if (r_state == S_DRAIN && !stall_in) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed and randomized checks of interrupt entry,
// stack push handshake, drain stalls, pending merge and reset behaviour.
`default_nettype none

module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        interrupt;
  logic [31:0] pc_next;
  logic [2:0]  flags;
  logic        stall_in;
  logic        rti_done;
  logic        push_ready;
  logic        freeze_fetch;
  logic        push_valid;
  logic [15:0] push_data;
  logic        pc_load;
  logic [31:0] pc_vector;
  logic        int_active;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] obs_words[$];
  int          obs_drain;
  int          obs_stall;
  int          obs_loads;
  logic [31:0] obs_vec;
  logic        obs_load_freeze;
  int          obs_hold_bad;
  int          obs_early;
  int          obs_gap;
  int          obs_lo_hold;
  logic        obs_done;

  logic [31:0] exp_pc;
  logic [2:0]  exp_flags;

  interrupt_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .interrupt    (interrupt),
    .pc_next      (pc_next),
    .flags        (flags),
    .stall_in     (stall_in),
    .rti_done     (rti_done),
    .push_ready   (push_ready),
    .freeze_fetch (freeze_fetch),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .pc_load      (pc_load),
    .pc_vector    (pc_vector),
    .int_active   (int_active)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_pin;
    interrupt = 1'b1;
    tick();
    tick();
    interrupt = 1'b0;
  endtask

  task automatic leave_service;
    rti_done = 1'b1;
    tick();
    rti_done = 1'b0;
  endtask

  function automatic logic [47:0] model_words(input logic [31:0] pc, input logic [2:0] f);
    logic [15:0] hi, lo, fw;
    hi = 16'(pc / 32'h1_0000);
    lo = 16'(pc % 32'h1_0000);
    fw = 16'(f);
    return {hi, lo, fw};
  endfunction

  function automatic logic [47:0] got_words();
    if (obs_words.size() != 3) return 48'hDEAD_DEAD_DEAD;
    return {obs_words[0], obs_words[1], obs_words[2]};
  endfunction

  // Runs one entry from the current cycle until int_active, recording what the
  // stack port and fetch controls did. ready/stall modes: 0 quiet, 1 random,
  // 2 directed (3 refusals on the low PC word / 2 stalls inside the drain).
  task automatic observe_entry(input int ready_mode, input int stall_mode, input bit noise);
    bit          seen;
    bit          prev_hold;
    logic [15:0] prev_data;
    int          lo_block;
    int          dcyc;
    obs_words.delete();
    obs_drain = 0; obs_stall = 0; obs_loads = 0; obs_vec = '0; obs_load_freeze = 1'b0;
    obs_hold_bad = 0; obs_early = 0; obs_gap = 0; obs_lo_hold = 0; obs_done = 1'b0;
    seen = 1'b0; prev_hold = 1'b0; prev_data = '0; lo_block = 0; dcyc = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      rti_done = 1'b0;
      if (int_active) begin
        obs_done = 1'b1;
        break;
      end
      if (freeze_fetch) seen = 1'b1;
      if (seen) begin
        pc_next = $urandom;
        flags   = 3'($urandom);
      end
      case (ready_mode)
        1: push_ready = ($urandom_range(0, 2) != 0);
        2: begin
          if (push_valid && obs_words.size() == 1 && lo_block < 3) begin
            push_ready = 1'b0;
            lo_block++;
            if (push_data === 16'h0A3C) obs_lo_hold++;
          end else begin
            push_ready = 1'b1;
          end
        end
        default: push_ready = 1'b1;
      endcase
      case (stall_mode)
        1: stall_in = ($urandom_range(0, 2) == 0);
        2: stall_in = freeze_fetch && !push_valid && (dcyc == 1 || dcyc == 2);
        default: stall_in = 1'b0;
      endcase
      if (noise) rti_done = ($urandom_range(0, 5) == 0);
      if (prev_hold && (!push_valid || push_data !== prev_data)) obs_hold_bad++;
      prev_hold = push_valid && !push_ready;
      prev_data = push_data;
      if (freeze_fetch && !push_valid) begin
        obs_drain++;
        dcyc++;
        if (stall_in) obs_stall++;
      end
      if (seen && obs_loads == 0 && !freeze_fetch && !pc_load) obs_gap++;
      if (push_valid && push_ready) obs_words.push_back(push_data);
      if (pc_load) begin
        obs_loads++;
        obs_vec         = pc_vector;
        obs_load_freeze = freeze_fetch;
        if (obs_words.size() != 3) obs_early++;
      end
      tick();
    end
    rti_done = 1'b0;
    stall_in = 1'b0;
  endtask

  task automatic test_reset;
    int busy;
    rst = 1'b0; interrupt = 1'b1; pc_next = 32'h1234_5678; flags = 3'b111;
    stall_in = 1'b0; rti_done = 1'b0; push_ready = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if ({freeze_fetch, push_valid, push_data, pc_load, int_active} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ff=%b pv=%b pd=%h pl=%b ia=%b, want all 0",
               freeze_fetch, push_valid, push_data, pc_load, int_active);
    end
    n_cmp++;
    if (pc_vector !== 32'h0000_0002) begin
      n_bad++;
      $display("FAIL reset_pc_vector: got %h want 00000002", pc_vector);
    end
    rst = 1'b1;
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (freeze_fetch || int_active || push_valid || pc_load) busy++;
    end
    n_cmp++;
    if (busy !== 0) begin
      n_bad++;
      $display("FAIL reset_pin_high_no_entry: got %0d busy cycles want 0", busy);
    end
    interrupt = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_basic;
    int lat;
    exp_pc = 32'h0001_0A3C; exp_flags = 3'b101;
    pc_next = exp_pc; flags = exp_flags; push_ready = 1'b1; stall_in = 1'b0;
    interrupt = 1'b1;
    lat = 0;
    while (!freeze_fetch && lat < 20) begin
      tick();
      lat++;
    end
    interrupt = 1'b0;
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL basic_latency: got %0d cycles want 4", lat);
    end
    observe_entry(0, 0, 1'b0);
    n_cmp++;
    if (obs_done !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_done: got %b want 1 (entry timed out)", obs_done);
    end
    n_cmp++;
    if (obs_drain !== 4) begin
      n_bad++;
      $display("FAIL basic_drain: got %0d want 4", obs_drain);
    end
    n_cmp++;
    if (got_words() !== 48'h0001_0A3C_0005) begin
      n_bad++;
      $display("FAIL basic_words: got %h want 00010a3c0005", got_words());
    end
    n_cmp++;
    if (obs_loads !== 1 || obs_vec !== 32'h0000_0002 || obs_load_freeze !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_jump: got loads=%0d vec=%h ff=%b want 1/00000002/0",
               obs_loads, obs_vec, obs_load_freeze);
    end
    n_cmp++;
    if (obs_gap !== 0) begin
      n_bad++;
      $display("FAIL basic_freeze_gap: got %0d want 0", obs_gap);
    end
    leave_service();
    n_cmp++;
    if (int_active !== 1'b0 || freeze_fetch !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_rti: got ia=%b ff=%b want 0/0", int_active, freeze_fetch);
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_backpressure;
    exp_pc = 32'h0001_0A3C; exp_flags = 3'b101;
    pc_next = exp_pc; flags = exp_flags;
    pulse_pin();
    observe_entry(2, 0, 1'b0);
    n_cmp++;
    if (obs_lo_hold !== 3 || obs_hold_bad !== 0) begin
      n_bad++;
      $display("FAIL bp_hold: got held=%0d unstable=%0d want 3/0", obs_lo_hold, obs_hold_bad);
    end
    n_cmp++;
    if (obs_early !== 0 || obs_loads !== 1) begin
      n_bad++;
      $display("FAIL bp_load: got early=%0d loads=%0d want 0/1", obs_early, obs_loads);
    end
    n_cmp++;
    if (got_words() !== model_words(exp_pc, exp_flags)) begin
      n_bad++;
      $display("FAIL bp_words: got %h want %h", got_words(), model_words(exp_pc, exp_flags));
    end
    leave_service();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_stall;
    exp_pc = $urandom; exp_flags = 3'($urandom);
    pc_next = exp_pc; flags = exp_flags;
    pulse_pin();
    observe_entry(0, 2, 1'b0);
    n_cmp++;
    if (obs_drain !== 6 || obs_stall !== 2) begin
      n_bad++;
      $display("FAIL stall_drain: got drain=%0d stalls=%0d want 6/2", obs_drain, obs_stall);
    end
    n_cmp++;
    if (obs_gap !== 0) begin
      n_bad++;
      $display("FAIL stall_freeze_gap: got %0d want 0", obs_gap);
    end
    n_cmp++;
    if (got_words() !== model_words(exp_pc, exp_flags)) begin
      n_bad++;
      $display("FAIL stall_words: got %h want %h", got_words(), model_words(exp_pc, exp_flags));
    end
    leave_service();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_pending;
    int extra;
    exp_pc = $urandom; exp_flags = 3'($urandom);
    pc_next = exp_pc; flags = exp_flags;
    pulse_pin();
    observe_entry(0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pulse_pin();
      tick(); tick(); tick();
    end
    n_cmp++;
    if (int_active !== 1'b1) begin
      n_bad++;
      $display("FAIL pend_still_active: got %b want 1", int_active);
    end
    leave_service();
    n_cmp++;
    if (int_active !== 1'b0 || freeze_fetch !== 1'b0) begin
      n_bad++;
      $display("FAIL pend_idle: got ia=%b ff=%b want 0/0", int_active, freeze_fetch);
    end
    exp_pc = $urandom; exp_flags = 3'($urandom);
    pc_next = exp_pc; flags = exp_flags;
    tick();
    n_cmp++;
    if (freeze_fetch !== 1'b1) begin
      n_bad++;
      $display("FAIL pend_reentry: got ff=%b want 1", freeze_fetch);
    end
    observe_entry(0, 0, 1'b0);
    n_cmp++;
    if (got_words() !== model_words(exp_pc, exp_flags)) begin
      n_bad++;
      $display("FAIL pend_words: got %h want %h", got_words(), model_words(exp_pc, exp_flags));
    end
    leave_service();
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (freeze_fetch || int_active) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_bad++;
      $display("FAIL pend_merge: got %0d busy cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid_push;
    int wait_c;
    int busy;
    pc_next = $urandom; flags = 3'($urandom);
    push_ready = 1'b0;
    pulse_pin();
    wait_c = 0;
    while (!freeze_fetch && wait_c < 20) begin
      tick();
      wait_c++;
    end
    pulse_pin();
    wait_c = 0;
    while (!push_valid && wait_c < 20) begin
      tick();
      wait_c++;
    end
    n_cmp++;
    if (push_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_reach_push: got pv=%b want 1", push_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (push_valid !== 1'b0 || freeze_fetch !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_async_drop: got pv=%b ff=%b want 0/0", push_valid, freeze_fetch);
    end
    tick(); tick();
    rst = 1'b1;
    push_ready = 1'b1;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pc_load || int_active || freeze_fetch) busy++;
    end
    n_cmp++;
    if (busy !== 0) begin
      n_bad++;
      $display("FAIL rstmid_no_resume: got %0d busy cycles want 0", busy);
    end
  endtask

  task automatic test_random;
    bit queued;
    int n_edges;
    queued = 1'b0;
    exp_pc = $urandom; exp_flags = 3'($urandom);
    pc_next = exp_pc; flags = exp_flags;
    for (int it = 0; it < 12; it++) begin
      if (!queued) pulse_pin();
      observe_entry(1, 1, 1'b1);
      n_cmp++;
      if (obs_done !== 1'b1 || got_words() !== model_words(exp_pc, exp_flags)) begin
        n_bad++;
        $display("FAIL rand_words[%0d]: got done=%b %h want 1 %h", it, obs_done,
                 got_words(), model_words(exp_pc, exp_flags));
      end
      n_cmp++;
      if (obs_drain !== 4 + obs_stall || obs_loads !== 1 || obs_early !== 0 ||
          obs_hold_bad !== 0 || obs_gap !== 0) begin
        n_bad++;
        $display("FAIL rand_seq[%0d]: got drain=%0d (stalls %0d) loads=%0d early=%0d unstable=%0d gap=%0d want %0d/1/0/0/0",
                 it, obs_drain, obs_stall, obs_loads, obs_early, obs_hold_bad, obs_gap, 4 + obs_stall);
      end
      n_edges = $urandom_range(0, 3);
      for (int e = 0; e < n_edges; e++) begin
        pulse_pin();
        tick(); tick(); tick();
      end
      tick(); tick(); tick(); tick();
      leave_service();
      n_cmp++;
      if (int_active !== 1'b0 || freeze_fetch !== 1'b0) begin
        n_bad++;
        $display("FAIL rand_idle[%0d]: got ia=%b ff=%b want 0/0", it, int_active, freeze_fetch);
      end
      exp_pc = $urandom; exp_flags = 3'($urandom);
      pc_next = exp_pc; flags = exp_flags;
      tick();
      queued = (n_edges > 0);
      n_cmp++;
      if (freeze_fetch !== queued) begin
        n_bad++;
        $display("FAIL rand_pending[%0d]: got ff=%b want %b", it, freeze_fetch, queued);
      end
      if (!queued) begin
        tick(); tick(); tick();
      end
    end
    if (queued) begin
      observe_entry(0, 0, 1'b0);
      leave_service();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; interrupt = 1'b0; pc_next = '0; flags = '0;
    stall_in = 1'b0; rti_done = 1'b0; push_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_pending();
    test_reset_mid_push();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
